// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, coordinate type and the ball FSM states.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int WALL_T   = 16;

    // Signed working width for coordinate arithmetic; wide enough that
    // pos - step never wraps and pad_y + PAD_H never overflows.
    typedef logic signed [11:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        MISS = 2'd2
    } state_t;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis clamp/reflect unit: advances pos by step in the current direction
// and reflects off the lo/hi limits (hi is compared against the far edge).
module ball_axis_step
    import pong_pkg::*;
(
    input  logic signed [11:0] pos,
    input  logic               dir,       // 1 = increasing coordinate
    input  logic signed [11:0] step,
    input  logic signed [11:0] lo,
    input  logic signed [11:0] hi,
    input  logic signed [11:0] size,
    output logic signed [11:0] moved_pos, // unclamped pos +/- step
    output logic signed [11:0] next_pos,
    output logic               next_dir,
    output logic               hit_lo,
    output logic               hit_hi
);

    // Move, then clamp and reflect if the new position touches a limit.
    always_comb begin
        moved_pos = dir ? (pos + step) : (pos - step);
        next_pos  = moved_pos;
        next_dir  = dir;
        hit_lo    = 1'b0;
        hit_hi    = 1'b0;
        if (!dir && (moved_pos <= lo)) begin
            next_pos = lo;
            next_dir = 1'b1;
            hit_lo   = 1'b1;
        end else if (dir && ((moved_pos + size) >= hi)) begin
            next_pos = hi - size;
            next_dir = 1'b0;
            hit_hi   = 1'b1;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous Pong ball controller: owns position/direction, bounces off
// walls and paddles once per enabled frame_tick, and flags hits and misses.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter int X0          = 316,
    parameter int Y0          = 236,
    parameter int BALL_W      = 8,
    parameter int BALL_H      = 8,
    parameter int STEP        = 4,
    parameter int TOP_BOUND   = WALL_T,
    parameter int BOT_BOUND   = SCREEN_H - WALL_T,
    parameter int LEFT_BOUND  = 24,
    parameter int RIGHT_BOUND = 616,
    parameter int PAD_H       = 64,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic        serve_right,
    input  logic        serve_down,
    input  logic [9:0]  left_pad_y,
    input  logic [9:0]  right_pad_y,
    output logic [10:0] xpos,
    output logic [9:0]  ypos,
    output logic        dir_x,
    output logic        dir_y,
    output logic        hit,
    output logic        miss_left,
    output logic        miss_right,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    state_t      state_q, state_d;
    logic [10:0] xpos_q, xpos_d;
    logic [9:0]  ypos_q, ypos_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        hit_q, hit_d;
    logic        miss_left_q, miss_left_d;
    logic        miss_right_q, miss_right_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;

    logic signed [11:0] x_cur, y_cur, pad_cur;
    logic signed [11:0] x_moved, x_next, y_moved, y_next;
    logic               x_ndir, y_ndir;
    logic               x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
    logic               overlap, advance;

    assign x_cur   = $signed({1'b0, xpos_q});
    assign y_cur   = $signed({2'b00, ypos_q});
    assign advance = enb && frame_tick;

    // Only the paddle the ball is heading toward matters; the overlap uses the
    // pre-update ypos so a simultaneous wall clamp cannot turn a hit into a miss.
    assign pad_cur = $signed({2'b00, (dir_x_q ? right_pad_y : left_pad_y)});
    assign overlap = (pad_cur < (y_cur + to_coord(BALL_H))) &&
                     ((pad_cur + to_coord(PAD_H)) > y_cur);

    ball_axis_step u_x_step (
        .pos       (x_cur),
        .dir       (dir_x_q),
        .step      (to_coord(STEP)),
        .lo        (to_coord(LEFT_BOUND)),
        .hi        (to_coord(RIGHT_BOUND)),
        .size      (to_coord(BALL_W)),
        .moved_pos (x_moved),
        .next_pos  (x_next),
        .next_dir  (x_ndir),
        .hit_lo    (x_hit_lo),
        .hit_hi    (x_hit_hi)
    );

    ball_axis_step u_y_step (
        .pos       (y_cur),
        .dir       (dir_y_q),
        .step      (to_coord(STEP)),
        .lo        (to_coord(TOP_BOUND)),
        .hi        (to_coord(BOT_BOUND)),
        .size      (to_coord(BALL_H)),
        .moved_pos (y_moved),
        .next_pos  (y_next),
        .next_dir  (y_ndir),
        .hit_lo    (y_hit_lo),
        .hit_hi    (y_hit_hi)
    );

    // Next-state and next-position logic for IDLE / MOVE / MISS.
    always_comb begin
        state_d      = state_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        hit_d        = 1'b0;
        miss_left_d  = 1'b0;
        miss_right_d = 1'b0;
        miss_cnt_d   = miss_cnt_q;
        case (state_q)
            IDLE: begin
                xpos_d = 11'(X0);
                ypos_d = 10'(Y0);
                if (serve) begin
                    dir_x_d = serve_right;
                    dir_y_d = serve_down;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (advance) begin
                    ypos_d  = y_next[9:0];
                    dir_y_d = y_ndir;
                    if (x_hit_lo || x_hit_hi) begin
                        if (overlap) begin
                            xpos_d  = x_next[10:0];
                            dir_x_d = x_ndir;
                            hit_d   = 1'b1;
                        end else begin
                            // Ball slips past the paddle face and freezes there.
                            xpos_d       = x_moved[10:0];
                            miss_left_d  = x_hit_lo;
                            miss_right_d = x_hit_hi;
                            state_d      = MISS;
                        end
                    end else begin
                        xpos_d = x_next[10:0];
                    end
                end
            end
            MISS: begin
                if (advance) begin
                    if (miss_cnt_q == 8'(MISS_FRAMES - 1)) begin
                        miss_cnt_d = 8'd0;
                        xpos_d     = 11'(X0);
                        ypos_d     = 10'(Y0);
                        state_d    = IDLE;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any rally immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            xpos_q       <= 11'(X0);
            ypos_q       <= 10'(Y0);
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            hit_q        <= 1'b0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
            miss_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            hit_q        <= hit_d;
            miss_left_q  <= miss_left_d;
            miss_right_q <= miss_right_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign dir_x      = dir_x_q;
    assign dir_y      = dir_y_q;
    assign hit        = hit_q;
    assign miss_left  = miss_left_q;
    assign miss_right = miss_right_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: a directed opening (reset, serve, pause, paddle
// hit, miss/recovery, corner bounce) followed by random play, all checked
// cycle by cycle against a behavioural model through expected-value queues.
// Valid/ready note: the DUT has no handshake; every clock edge is a
// "transaction", so one expected vector is queued per driven cycle and the
// monitor pops one vector 1 time unit after each rising edge.
module tb_ball_motion_ctrl;

    localparam int W = 27;

    // Model phases (behavioural, not the DUT encoding)
    localparam int PH_WAIT   = 0;
    localparam int PH_PLAY   = 1;
    localparam int PH_PENALTY = 2;

    typedef struct {
        int x;
        int y;
        bit dx;
        bit dy;
        int phase;
        int frames;
        bit hit;
        bit ml;
        bit mr;
    } mdl_t;

    // ---------------- clock / reset / DUT signals ----------------
    logic        clk = 1'b0;
    logic        reset, enb, frame_tick, serve, serve_right, serve_down;
    logic [9:0]  left_pad_y, right_pad_y;

    logic [10:0] a_xpos, b_xpos;
    logic [9:0]  a_ypos, b_ypos;
    logic        a_dir_x, a_dir_y, a_hit, a_ml, a_mr, a_busy;
    logic        b_dir_x, b_dir_y, b_hit, b_ml, b_mr, b_busy;
    logic [1:0]  a_state, b_state;

    always #5 clk = ~clk;

    // Main instance: default geometry.
    ball_motion_ctrl u_dut (
        .clk(clk), .reset(reset), .enb(enb), .frame_tick(frame_tick),
        .serve(serve), .serve_right(serve_right), .serve_down(serve_down),
        .left_pad_y(left_pad_y), .right_pad_y(right_pad_y),
        .xpos(a_xpos), .ypos(a_ypos), .dir_x(a_dir_x), .dir_y(a_dir_y),
        .hit(a_hit), .miss_left(a_ml), .miss_right(a_mr), .busy(a_busy),
        .state_dbg(a_state)
    );

    // Second instance serving from next to the bottom-left corner, so one
    // tick can hit the bottom wall and the left paddle together.
    ball_motion_ctrl #(.X0(28), .Y0(452)) u_dut_corner (
        .clk(clk), .reset(reset), .enb(enb), .frame_tick(frame_tick),
        .serve(serve), .serve_right(serve_right), .serve_down(serve_down),
        .left_pad_y(left_pad_y), .right_pad_y(right_pad_y),
        .xpos(b_xpos), .ypos(b_ypos), .dir_x(b_dir_x), .dir_y(b_dir_y),
        .hit(b_hit), .miss_left(b_ml), .miss_right(b_mr), .busy(b_busy),
        .state_dbg(b_state)
    );

    // ---------------- reference model ----------------
    mdl_t m_a, m_b;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_c_q[$];
    int checks = 0;
    int errors = 0;

    function automatic mdl_t model_step(input mdl_t s, input int x0, input int y0,
                                        input bit rst, input bit en, input bit tick,
                                        input bit srv, input bit sr, input bit sd,
                                        input int lp, input int rp);
        mdl_t n;
        int ny, nx, pad;
        n = s;
        n.hit = 0; n.ml = 0; n.mr = 0;
        if (rst) begin
            n.x = x0; n.y = y0; n.dx = 1; n.dy = 1;
            n.phase = PH_WAIT; n.frames = 0;
            return n;
        end
        if (n.phase == PH_WAIT) begin
            if (srv) begin
                n.dx = sr; n.dy = sd; n.phase = PH_PLAY;
            end
        end else if (n.phase == PH_PLAY) begin
            if (en && tick) begin
                ny = s.dy ? s.y + 4 : s.y - 4;
                if (!s.dy && ny <= 16) begin
                    n.y = 16; n.dy = 1;
                end else if (s.dy && ny + 8 >= 464) begin
                    n.y = 456; n.dy = 0;
                end else begin
                    n.y = ny;
                end
                nx = s.dx ? s.x + 4 : s.x - 4;
                if ((!s.dx && nx <= 24) || (s.dx && nx + 8 >= 616)) begin
                    pad = s.dx ? rp : lp;
                    if (pad < s.y + 8 && pad + 64 > s.y) begin
                        n.x = s.dx ? 608 : 24;
                        n.dx = !s.dx;
                        n.hit = 1;
                    end else begin
                        n.x = nx;
                        if (s.dx) n.mr = 1; else n.ml = 1;
                        n.phase = PH_PENALTY;
                    end
                end else begin
                    n.x = nx;
                end
            end
        end else begin
            if (en && tick) begin
                n.frames = s.frames + 1;
                if (n.frames == 60) begin
                    n.frames = 0; n.x = x0; n.y = y0; n.phase = PH_WAIT;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [W-1:0] pack(input mdl_t s);
        return {11'(s.x), 10'(s.y), s.dx, s.dy, s.hit, s.ml, s.mr, (s.phase != PH_WAIT)};
    endfunction

    function automatic int clip_pad(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst, input bit en, input bit tick, input bit srv,
                         input bit sr, input bit sd, input int lp, input int rp);
        @(negedge clk);
        reset       = rst;
        enb         = en;
        frame_tick  = tick;
        serve       = srv;
        serve_right = sr;
        serve_down  = sd;
        left_pad_y  = 10'(lp);
        right_pad_y = 10'(rp);
        m_a = model_step(m_a, 316, 236, rst, en, tick, srv, sr, sd, lp, rp);
        m_b = model_step(m_b, 28, 452, rst, en, tick, srv, sr, sd, lp, rp);
        exp_q.push_back(pack(m_a));
        exp_c_q.push_back(pack(m_b));
    endtask

    // Pad that usually covers the ball's current row, sometimes not.
    function automatic int track_pad(input int y);
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 479);
        return clip_pad(y + 8 - int'($urandom_range(0, 90)));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always begin
        logic [W-1:0] e, act;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {a_xpos, a_ypos, a_dir_x, a_dir_y, a_hit, a_ml, a_mr, a_busy};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL main_outputs t=%0t got x=%0d y=%0d dx=%b dy=%b hit=%b ml=%b mr=%b busy=%b exp x=%0d y=%0d dx=%b dy=%b hit=%b ml=%b mr=%b busy=%b",
                         $time, act[26:16], act[15:6], act[5], act[4], act[3], act[2], act[1], act[0],
                         e[26:16], e[15:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
        if (exp_c_q.size() > 0) begin
            e   = exp_c_q.pop_front();
            act = {b_xpos, b_ypos, b_dir_x, b_dir_y, b_hit, b_ml, b_mr, b_busy};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL corner_outputs t=%0t got x=%0d y=%0d dx=%b dy=%b hit=%b ml=%b mr=%b busy=%b exp x=%0d y=%0d dx=%b dy=%b hit=%b ml=%b mr=%b busy=%b",
                         $time, act[26:16], act[15:6], act[5], act[4], act[3], act[2], act[1], act[0],
                         e[26:16], e[15:6], e[5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; enb = 1'b0; frame_tick = 1'b0; serve = 1'b0;
        serve_right = 1'b0; serve_down = 1'b0; left_pad_y = '0; right_pad_y = '0;
        m_a = '{x: 0, y: 0, dx: 0, dy: 0, phase: 0, frames: 0, hit: 0, ml: 0, mr: 0};
        m_b = m_a;

        // Reset values, then ticks in IDLE have no effect.
        repeat (3) drive(1, 1, 1, 0, 0, 0, 100, 100);
        repeat (3) drive(0, 1, 1, 0, 0, 0, 100, 100);
        // Serve right/down, one tick: 316,236 -> 320,240.
        drive(0, 1, 0, 1, 1, 1, 100, 100);
        drive(0, 1, 1, 0, 0, 0, 100, 100);
        repeat (5) drive(0, 1, 1, 0, 0, 0, 100, 100);
        // Reset mid-MOVE aborts to serve position.
        drive(1, 1, 1, 0, 0, 0, 100, 100);
        drive(0, 1, 0, 0, 0, 0, 100, 100);

        // Corner case on the second instance: left/down serve, overlapping left pad.
        drive(0, 1, 0, 1, 0, 1, 430, 100);
        drive(0, 1, 1, 0, 0, 0, 430, 100);
        drive(0, 1, 0, 0, 0, 0, 430, 100);

        // Pause: 10 ticks with enb low hold position; then one enabled tick.
        drive(1, 1, 0, 0, 0, 0, 100, 100);
        drive(0, 0, 0, 1, 1, 0, 100, 100);
        repeat (10) drive(0, 0, 1, 0, 0, 0, 100, 100);
        drive(0, 1, 1, 0, 0, 0, 100, 100);

        // Right paddle hit with a paddle tracking the ball.
        drive(1, 1, 0, 0, 0, 0, 100, 100);
        drive(0, 1, 0, 1, 1, 1, 100, 100);
        repeat (80) drive(0, 1, 1, 0, 0, 0, 0, clip_pad(m_a.y - 20));

        // Right miss with pads parked at 0, serve attempt during MISS, recovery.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1, 1, 0, 0);
        repeat (75) drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (62) drive(0, 1, 1, 0, 0, 0, 0, 0);

        // Random play.
        for (int i = 0; i < 20000; i++) begin
            drive($urandom_range(0, 2999) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  track_pad(m_a.y), track_pad(m_a.y));
        end

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || exp_c_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d pending, expected 0/0", exp_q.size(), exp_c_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Frame-synchronous motion controller for the Pong ball rectangle.
- Owns the ball's position and direction registers and advances them once per video frame.
- Bounces the ball off the top and bottom walls and off the paddles; detects misses.
- Drives the runtime X/Y position consumed by a position-programmable rectangle generator in the VGA pixel path, and flags hits and misses to the score logic.

Parameters:
- X0, 316, ball reset/serve X (left edge, pixels)
- Y0, 236, ball reset/serve Y (top edge, pixels)
- BALL_W, 8, ball width
- BALL_H, 8, ball height
- STEP, 4, pixels moved per axis per frame (1..15)
- TOP_BOUND, 16, lowest legal ball top edge (bottom of top wall)
- BOT_BOUND, 464, highest legal ball bottom edge (top of bottom wall)
- LEFT_BOUND, 24, left paddle face X
- RIGHT_BOUND, 616, right paddle face X
- PAD_H, 64, paddle height
- MISS_FRAMES, 60, frames held in MISS before auto-return to IDLE

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- enb  in  1  motion enable (pause when low)
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- serve  in  1  one-cycle pulse; launches ball from IDLE
- serve_right  in  1  serve X direction (1 = right), sampled with serve
- serve_down  in  1  serve Y direction (1 = down), sampled with serve
- left_pad_y  in  10  left paddle top edge
- right_pad_y  in  10  right paddle top edge
- xpos  out  11  ball left edge
- ypos  out  10  ball top edge
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 = moving down
- hit  out  1  one-cycle pulse on paddle bounce
- miss_left  out  1  one-cycle pulse; ball passed left paddle
- miss_right  out  1  one-cycle pulse; ball passed right paddle
- busy  out  1  high in MOVE or MISS

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: xpos=X0, ypos=Y0, dir_x=1, dir_y=1, hit/miss pulses=0, state=IDLE, miss counter=0. Reset asserted mid-MOVE or mid-MISS aborts immediately to these values.
- All outputs are registered. An update sampled on the clk edge with frame_tick=1 is visible on the outputs one cycle later. Pulses last exactly one cycle.
- frame_tick is ignored while enb=0 in every state: position and MISS counter hold. serve is still accepted while enb=0.
- States:
  - IDLE: position held at X0/Y0. serve=1 latches dir_x=serve_right, dir_y=serve_down, then goes to MOVE. frame_tick has no effect.
  - MOVE: on each enabled frame_tick, both axes update in the same cycle. serve is ignored.
  - MISS: counts enabled frame_ticks. When the count reaches MISS_FRAMES, the counter clears, position goes to X0/Y0, and the state goes to IDLE. serve is ignored.
- Y axis arithmetic is done 12-bit signed, so there is no underflow:
  - ny = ypos ± STEP.
  - If moving up and ny <= TOP_BOUND: ypos=TOP_BOUND, dir_y=1.
  - If moving down and ny+BALL_H >= BOT_BOUND: ypos=BOT_BOUND-BALL_H, dir_y=0.
  - Otherwise ypos=ny.
- X axis:
  - nx = xpos ± STEP.
  - Boundary condition: moving left with nx <= LEFT_BOUND, or moving right with nx+BALL_W >= RIGHT_BOUND.
  - Overlap test against the facing paddle uses the pre-update ypos: pad_y < ypos+BALL_H AND pad_y+PAD_H > ypos (strict both sides).
  - Overlap true: clamp xpos to LEFT_BOUND or RIGHT_BOUND-BALL_W, flip dir_x, pulse hit.
  - Overlap false: xpos=nx, pulse miss_left or miss_right, enter MISS.
- Simultaneous wall bounce and paddle hit/miss on the same tick: both axis results apply, and only one x-event pulse fires.
- busy = (state != IDLE).

Decomposition:
- Shared package pong_pkg:
  - state typedef {IDLE, MOVE, MISS}
  - screen geometry constants (640x480, wall thickness)
  - 12-bit signed coordinate type
- One natural sub-module, ball_axis_step: a per-axis clamp/reflect unit.
  - Inputs: pos, dir, step, lo, hi, size.
  - Outputs: next_pos, next_dir, hit_lo, hit_hi.
  - Instantiated once for X and once for Y. The X instance's hit flags feed the paddle-overlap decision in the parent.

Test Plan:
- Reset and serve: assert reset mid-run → xpos=316, ypos=236, busy=0. Then serve with serve_right=1, serve_down=1, plus one frame_tick → xpos=320, ypos=240, busy=1.
- Top wall bounce: Y0=20, serve_down=0, one tick → ny=16 <= 16 → ypos=16, dir_y=1. Next tick → ypos=20.
- Pause: enb=0 with 10 frame_ticks in MOVE → xpos/ypos unchanged. enb=1 with one tick → position advances by 4.
- Right paddle hit: right_pad_y=200, ball moving right reaches nx+8 >= 616 with ypos=236 → xpos=608, dir_x=0, one-cycle hit, no miss.
- Right miss and recovery: right_pad_y=0, ypos=236 → miss_right pulse, state MISS. After exactly 60 enabled ticks → xpos=316, ypos=236, busy=0. A serve during MISS is ignored.
- Corner event: ball reaches the bottom wall and the left paddle face on the same tick with overlap → ypos=456, dir_y=0, xpos=24, dir_x=1, single hit pulse.
